// File: rtl/crc16_frame_tx.sv
// Frames a payload byte stream as SYNC0 SYNC1 payload CRC_LO CRC_HI. The trailer is CRC-16/USB and is sent low byte first.
// The output is registered and stalls hold m_data/m_valid; s_ready is only high while payload can flow.
module crc16_frame_tx #(
  parameter logic [7:0]  SYNC0      = 8'hEB,
  parameter logic [7:0]  SYNC1      = 8'h90,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        busy,
  output logic [15:0] frame_cnt
);
  localparam int GW = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SYNC0, S_SYNC1, S_DATA, S_CRC_LO, S_CRC_HI, S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    m_data_q, m_data_d;
  logic          m_valid_q, m_valid_d;
  logic          busy_q, busy_d;
  logic          hi_q, hi_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic [15:0]   crc_q, crc_d;
  logic [15:0]   crc_final;
  logic [GW-1:0] gap_q, gap_d;
  logic          free;
  logic          s_fire;

  // The register holds the non-reflected form, so data bits enter LSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[15] ^ d[i];
      r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
    end
    return r;
  endfunction

  always_comb begin
    crc_final = 16'h0000;
    for (int i = 0; i < 16; i++) crc_final[i] = ~crc_q[15-i];
  end

  assign free    = !m_valid_q || m_ready;
  assign s_ready = ((state_q == S_SYNC1) || (state_q == S_DATA)) && free;
  assign s_fire  = s_valid && s_ready;

  always_comb begin
    state_d     = state_q;
    m_data_d    = m_data_q;
    m_valid_d   = m_valid_q;
    busy_d      = busy_q;
    hi_d        = hi_q;
    frame_cnt_d = frame_cnt_q;
    crc_d       = crc_q;
    gap_d       = gap_q;
    case (state_q)
      S_IDLE: begin
        if (s_valid) begin
          crc_d     = 16'hFFFF;
          busy_d    = 1'b1;
          m_data_d  = SYNC0;
          m_valid_d = 1'b1;
          state_d   = S_SYNC0;
        end
      end
      S_SYNC0: begin
        if (m_ready) begin
          m_data_d = SYNC1;
          state_d  = S_SYNC1;
        end
      end
      S_SYNC1, S_DATA: begin
        if (s_fire) begin
          m_data_d  = s_data;
          m_valid_d = 1'b1;
          crc_d     = crc_byte(crc_q, s_data);
          state_d   = s_last ? S_CRC_LO : S_DATA;
        end else if (free) begin
          m_valid_d = 1'b0;
          state_d   = S_DATA;
        end
      end
      S_CRC_LO: begin
        if (free) begin
          m_data_d  = crc_final[7:0];
          m_valid_d = 1'b1;
          hi_d      = 1'b0;
          state_d   = S_CRC_HI;
        end
      end
      S_CRC_HI: begin
        // hi_q tells whether the byte on the output is the low or the high trailer byte.
        if (m_ready) begin
          if (!hi_q) begin
            m_data_d = crc_final[15:8];
            hi_d     = 1'b1;
          end else begin
            m_valid_d   = 1'b0;
            hi_d        = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            gap_d       = GW'(GAP_CYCLES);
            if (GAP_CYCLES == 0) begin
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end else begin
              state_d = S_GAP;
            end
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q - GW'(1);
        // The last gap cycle doubles as the idle cycle, so a waiting source loses exactly GAP_CYCLES.
        if (gap_q <= GW'(1)) begin
          if (s_valid) begin
            crc_d     = 16'hFFFF;
            m_data_d  = SYNC0;
            m_valid_d = 1'b1;
            state_d   = S_SYNC0;
          end else begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      m_data_q    <= 8'h00;
      m_valid_q   <= 1'b0;
      busy_q      <= 1'b0;
      hi_q        <= 1'b0;
      frame_cnt_q <= 16'h0000;
      crc_q       <= 16'hFFFF;
      gap_q       <= '0;
    end else begin
      state_q     <= state_d;
      m_data_q    <= m_data_d;
      m_valid_q   <= m_valid_d;
      busy_q      <= busy_d;
      hi_q        <= hi_d;
      frame_cnt_q <= frame_cnt_d;
      crc_q       <= crc_d;
      gap_q       <= gap_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign busy      = busy_q;
  assign frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_crc16_frame_tx.sv
// Directed bench for crc16_frame_tx: check value, single byte, backpressure, source gaps, back-to-back and mid-frame reset.
module tb_crc16_frame_tx;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_last = 1'b0;
  logic        s_ready;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        busy;
  logic [15:0] frame_cnt;

  crc16_frame_tx #(.SYNC0(8'hEB), .SYNC1(8'h90), .GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          stall_err = 0;
  int          stall_seen = 0;
  bit          rand_rdy = 1'b0;
  logic [7:0]  out_q[$];
  int          out_cyc[$];
  logic [8:0]  pay[$];
  logic [7:0]  exp_q[$];
  bit          vld_log[0:16383];
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_data = 8'h00;

  // Output monitor: records every accepted byte and any change while stalled.
  always @(negedge clk) begin
    if (cyc < 16384) vld_log[cyc] = m_valid;
    if (rst && prev_stall && (!m_valid || m_data !== prev_data)) stall_err++;
    if (rst && m_valid && m_ready) begin
      out_q.push_back(m_data);
      out_cyc.push_back(cyc);
    end
    if (rst && m_valid && !m_ready) stall_seen++;
    prev_stall = rst && m_valid && !m_ready;
    prev_data  = m_data;
    cyc++;
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      m_ready = ($urandom_range(0, 1) == 1);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, required all tests to finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] crc_usb_ref();
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (pay[i]) begin
      c = c ^ {8'h00, pay[i][7:0]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic clear_out();
    out_q.delete();
    out_cyc.delete();
    exp_q.delete();
    pay.delete();
  endtask

  task automatic load_digits(input int frames);
    for (int f = 0; f < frames; f++) begin
      exp_q.push_back(8'hEB);
      exp_q.push_back(8'h90);
      for (int d = 0; d < 9; d++) begin
        pay.push_back({(d == 8), 8'(8'h31 + d)});
        exp_q.push_back(8'(8'h31 + d));
      end
      exp_q.push_back(8'hC8);
      exp_q.push_back(8'hB4);
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic last);
    bit hs;
    int n;
    s_valid = 1'b1; s_data = d; s_last = last;
    hs = 1'b0; n = 0;
    while (!hs && n < 3000) begin
      @(negedge clk); hs = s_ready;
      @(posedge clk); #1; n++;
    end
    if (!hs) begin
      checks++;
      $display("FAIL push_timeout: byte %h not accepted, s_ready=%b, required acceptance", d, s_ready);
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_payload(input int gap);
    for (int i = 0; i < pay.size(); i++) begin
      push_byte(pay[i][7:0], pay[i][8]);
      if (gap > 0 && i < pay.size() - 1) begin
        repeat (gap) @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_out(input int n);
    int t;
    t = 0;
    while (out_q.size() < n && t < 3000) begin
      @(posedge clk); t++;
    end
    if (out_q.size() < n) begin
      checks++;
      $display("FAIL wait_out: got %0d output bytes, required %0d", out_q.size(), n);
    end
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    #3;
    checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b, required 0", m_valid); else passed++;
    checks++; if (m_data !== 8'h00) $display("FAIL reset_m_data: got %h, required 00", m_data); else passed++;
    checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b, required 0", s_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else passed++;
    checks++; if (frame_cnt !== 16'h0000) $display("FAIL reset_frame_cnt: got %h, required 0000", frame_cnt); else passed++;
    @(posedge clk); @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_check_value();
    int c;
    clear_out(); m_ready = 1'b1;
    load_digits(1);
    send_payload(0);
    wait_out(13);
    checks++; if (out_q.size() !== 13) $display("FAIL chk_count: got %0d bytes, required 13", out_q.size()); else passed++;
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (i >= out_q.size()) $display("FAIL chk_byte%0d: missing, required %h", i, exp_q[i]);
      else if (out_q[i] !== exp_q[i]) $display("FAIL chk_byte%0d: got %h, required %h", i, out_q[i], exp_q[i]);
      else passed++;
    end
    if (out_q.size() == 13) begin
      c = out_cyc[12];
      checks++; if (c - out_cyc[0] !== 12) $display("FAIL chk_consecutive: span %0d cycles, required 12", c - out_cyc[0]); else passed++;
      checks++; if (vld_log[c+1] !== 1'b0 || vld_log[c+2] !== 1'b0)
        $display("FAIL chk_idle_after: m_valid %b %b, required 0 0", vld_log[c+1], vld_log[c+2]); else passed++;
    end
    checks++; if (frame_cnt !== 16'd1) $display("FAIL chk_frame_cnt: got %0d, required 1", frame_cnt); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL chk_busy_idle: got %b, required 0", busy); else passed++;
  endtask

  task automatic test_single_byte();
    logic [7:0]  e[5];
    logic [15:0] ref_crc;
    clear_out(); m_ready = 1'b1;
    pay.push_back({1'b1, 8'h00});
    e[0] = 8'hEB; e[1] = 8'h90; e[2] = 8'h00; e[3] = 8'h40; e[4] = 8'hBF;
    ref_crc = crc_usb_ref();
    send_payload(0);
    wait_out(5);
    checks++; if (out_q.size() !== 5) $display("FAIL single_count: got %0d bytes, required 5", out_q.size()); else passed++;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= out_q.size()) $display("FAIL single_byte%0d: missing, required %h", i, e[i]);
      else if (out_q[i] !== e[i]) $display("FAIL single_byte%0d: got %h, required %h", i, out_q[i], e[i]);
      else passed++;
    end
    if (out_q.size() == 5) begin
      checks++;
      if ({out_q[4], out_q[3]} !== ref_crc)
        $display("FAIL single_vs_model: trailer %h, required %h", {out_q[4], out_q[3]}, ref_crc);
      else passed++;
    end
    checks++; if (frame_cnt !== 16'd2) $display("FAIL single_frame_cnt: got %0d, required 2", frame_cnt); else passed++;
  endtask

  task automatic test_backpressure();
    clear_out();
    stall_err = 0; stall_seen = 0;
    load_digits(1);
    rand_rdy = 1'b1;
    send_payload(0);
    wait_out(13);
    rand_rdy = 1'b0; m_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++; if (out_q.size() !== 13) $display("FAIL bp_count: got %0d bytes, required 13", out_q.size()); else passed++;
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (i >= out_q.size()) $display("FAIL bp_byte%0d: missing, required %h", i, exp_q[i]);
      else if (out_q[i] !== exp_q[i]) $display("FAIL bp_byte%0d: got %h, required %h", i, out_q[i], exp_q[i]);
      else passed++;
    end
    checks++; if (stall_err !== 0) $display("FAIL bp_stable: %0d changes while stalled, required 0", stall_err); else passed++;
    checks++; if (frame_cnt !== 16'd3) $display("FAIL bp_frame_cnt: got %0d, required 3", frame_cnt); else passed++;
  endtask

  task automatic test_source_gaps();
    int nv;
    clear_out(); m_ready = 1'b1;
    load_digits(1);
    send_payload(3);
    wait_out(13);
    checks++; if (out_q.size() !== 13) $display("FAIL gaps_count: got %0d bytes, required 13", out_q.size()); else passed++;
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (i >= out_q.size()) $display("FAIL gaps_byte%0d: missing, required %h", i, exp_q[i]);
      else if (out_q[i] !== exp_q[i]) $display("FAIL gaps_byte%0d: got %h, required %h", i, out_q[i], exp_q[i]);
      else passed++;
    end
    if (out_q.size() == 13) begin
      nv = 0;
      for (int k = out_cyc[0]; k <= out_cyc[12]; k++) nv += int'(vld_log[k]);
      checks++; if (out_cyc[12] - out_cyc[0] !== 36) $display("FAIL gaps_span: got %0d cycles, required 36", out_cyc[12] - out_cyc[0]); else passed++;
      checks++; if (nv !== 13) $display("FAIL gaps_valid_cycles: got %0d, required 13", nv); else passed++;
    end
    checks++; if (frame_cnt !== 16'd4) $display("FAIL gaps_frame_cnt: got %0d, required 4", frame_cnt); else passed++;
  endtask

  task automatic test_back_to_back();
    clear_out(); m_ready = 1'b1;
    load_digits(2);
    send_payload(0);
    wait_out(26);
    checks++; if (out_q.size() !== 26) $display("FAIL b2b_count: got %0d bytes, required 26", out_q.size()); else passed++;
    for (int i = 0; i < 26; i++) begin
      checks++;
      if (i >= out_q.size()) $display("FAIL b2b_byte%0d: missing, required %h", i, exp_q[i]);
      else if (out_q[i] !== exp_q[i]) $display("FAIL b2b_byte%0d: got %h, required %h", i, out_q[i], exp_q[i]);
      else passed++;
    end
    if (out_q.size() == 26) begin
      checks++;
      if (out_cyc[13] - out_cyc[12] - 1 !== GAP)
        $display("FAIL b2b_gap: got %0d idle cycles, required %0d", out_cyc[13] - out_cyc[12] - 1, GAP);
      else passed++;
    end
    checks++; if (frame_cnt !== 16'd6) $display("FAIL b2b_frame_cnt: got %0d, required 6", frame_cnt); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    clear_out(); m_ready = 1'b1;
    for (int d = 0; d < 4; d++) pay.push_back({1'b0, 8'(8'h31 + d)});
    send_payload(0);
    #2 rst = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) $display("FAIL mid_rst_m_valid: got %b, required 0", m_valid); else passed++;
    checks++; if (m_data !== 8'h00) $display("FAIL mid_rst_m_data: got %h, required 00", m_data); else passed++;
    checks++; if (s_ready !== 1'b0) $display("FAIL mid_rst_s_ready: got %b, required 0", s_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b, required 0", busy); else passed++;
    checks++; if (frame_cnt !== 16'd0) $display("FAIL mid_rst_frame_cnt: got %0d, required 0", frame_cnt); else passed++;
    @(posedge clk); #1 rst = 1'b1;
    clear_out();
    load_digits(1);
    send_payload(0);
    wait_out(13);
    checks++; if (out_q.size() !== 13) $display("FAIL mid_rst_count: got %0d bytes, required 13", out_q.size()); else passed++;
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (i >= out_q.size()) $display("FAIL mid_rst_byte%0d: missing, required %h", i, exp_q[i]);
      else if (out_q[i] !== exp_q[i]) $display("FAIL mid_rst_byte%0d: got %h, required %h", i, out_q[i], exp_q[i]);
      else passed++;
    end
    checks++; if (frame_cnt !== 16'd1) $display("FAIL mid_rst_frame_cnt_after: got %0d, required 1", frame_cnt); else passed++;
  endtask

  initial begin
    test_reset();
    test_check_value();
    test_single_byte();
    test_backpressure();
    test_source_gaps();
    test_back_to_back();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/crc16_frame_tx.md
Name: crc16_frame_tx

Overview:
- Byte-stream framer for the outbound link. Accepts raw payload bytes from the packet source and emits a framed stream: 2 sync bytes, the payload passed through unchanged, then the CRC-16/USB trailer.
- Directly upstream of the link serializer. Computes the same CRC-16/USB as crc_16 (poly 0x8005 reflected, init 0xFFFF, reflected in/out, final XOR 0xFFFF).
- The CRC register is re-initialised synchronously at every frame start, so no reset pulse is needed between frames.

Parameters:
- SYNC0, 8'hEB, first sync byte
- SYNC1, 8'h90, second sync byte
- GAP_CYCLES, 2, minimum idle cycles after CRC_HI is accepted before the next SYNC0 is presented (0 allowed)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous active-low reset
- s_data  in  8  payload byte
- s_valid  in  1  payload byte valid
- s_last  in  1  marks last payload byte of frame, qualified by s_valid
- s_ready  out  1  block accepts s_data this cycle
- m_data  out  8  framed output byte
- m_valid  out  1  m_data valid
- m_ready  in  1  downstream accepts m_data
- busy  out  1  high from frame start until GAP done
- frame_cnt  out  16  frames completed, wraps 0xFFFF->0

Behaviour:
- Reset (rst low, async): state IDLE, m_valid=0, m_data=0, s_ready=0, busy=0, frame_cnt=0, crc=16'hFFFF, gap counter=0.
- Transfer rule: a transfer occurs on an interface when valid and ready are both high at a posedge. m_data and m_valid are registered. While m_valid=1 and m_ready=0, m_data and m_valid hold stable.
- Output register "free" = (!m_valid || m_ready).

State machine (IDLE, SYNC0, SYNC1, DATA, CRC_LO, CRC_HI, GAP):
- IDLE: s_ready=0. When s_valid=1 (byte not consumed), load crc=16'hFFFF, set busy=1, and present m_data=SYNC0 with m_valid=1 on the next cycle -> state SYNC0.
- SYNC0: on m transfer, present SYNC1 -> SYNC1.
- SYNC1: on m transfer -> DATA. s_ready is already high in this cycle if m_ready=1, so there are no bubbles.
- DATA: s_ready = free.
  - On s transfer: m_data<=s_data, m_valid<=1, and crc updates with s_data (1 cycle).
  - If s_last=1 on that transfer -> CRC_LO.
  - If free and no s transfer: m_valid<=0 (bubble passes through).
- CRC_LO: s_ready=0. When free, present the low byte of the final CRC -> CRC_HI.
- CRC_HI: on transfer of the low byte, present the high byte.
  - On its transfer: m_valid<=0, frame_cnt+=1, load gap counter.
  - Go to GAP, or to IDLE if GAP_CYCLES=0.
- GAP: s_ready=0, m_valid=0. Count GAP_CYCLES cycles, then go to IDLE with busy=0.

CRC rules:
- Final CRC = bit-reversed(crc) XOR 16'hFFFF, bit-identical to crc_16 crc_out after the same payload.
- Byte order: low byte ([7:0]) first, then high byte ([15:8]).
- Payload length is 1..unbounded. The CRC covers payload only; sync bytes are excluded.
- Zero-length frames are impossible: a frame always starts from a valid byte.

Boundary conditions:
- s_valid dropping mid-frame: the frame stays in DATA indefinitely. There is no timeout.
- s_last together with a stalled m_ready: the byte is not accepted until free, so s_last is only honoured on the transfer itself.
- s_valid high in CRC_LO, CRC_HI or GAP: ignored, s_ready stays 0. The byte is held by the source and starts the next frame.
- rst asserted mid-frame: immediate return to reset values. The partial frame is lost and no CRC is sent.
- frame_cnt wraps from 0xFFFF to 0.

Test Plan:
- Check value: payload ASCII "123456789" (0x31..0x39, s_last on 0x39), m_ready=1 -> output EB 90 31..39 C8 B4 on consecutive cycles, then m_valid=0 for 2 cycles, and frame_cnt=1.
- Single byte: payload 0x00 -> EB 90 00 then the CRC trailer. The 16-bit trailer value must equal crc_16 crc_out after feeding 0x00, compared against a crc_16 instance in the bench.
- Backpressure: "123456789" with m_ready toggled randomly at 50% -> identical byte sequence, no drops or duplicates. m_data stays stable while stalled.
- Source gaps: s_valid deasserted 3 cycles between each payload byte -> same CRC C8 B4, with bubbles on m_valid only.
- Back-to-back frames: two "123456789" frames with s_valid held high -> exactly GAP_CYCLES idle cycles between the B4 byte and the second EB. Both trailers are C8 B4 (CRC re-initialised), and frame_cnt=2.
- Reset mid-frame: rst low after 4 payload bytes -> all outputs at reset values within the same cycle. The next frame "123456789" produces a correct C8 B4 trailer.
